// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int          ITERS   = 32;
    localparam int          COUNT_W = 5;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

    // Unsigned magnitude of a two's-complement word; |INT_MIN| stays 0x80000000.
    function automatic logic [31:0] mag(input logic signed [31:0] x);
        return x[31] ? 32'(-x) : 32'(x);
    endfunction

endpackage

// File: rtl/multdiv_seq_addsub.sv
// 32-bit adder/subtractor shared by the Booth multiply and restoring divide.
module addsub32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum,
    output logic        carry,
    output logic        overflow
);

    logic [31:0] b_eff;

    assign b_eff           = b ^ {32{sub}};
    assign {carry, sum}    = {1'b0, a} + {1'b0, b_eff} + {32'b0, sub};
    assign overflow        = (a[31] == b_eff[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide: 32 Booth or restoring iterations through one
// shared adder, plus one finishing cycle, then a one-cycle DONE with the RDY pulse.
module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    import multdiv_pkg::*;

    state_t             state;
    logic [COUNT_W-1:0] count;
    logic               fin;

    // acc is the Booth accumulator or the divide remainder; qreg holds Q / quotient.
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   qreg;
    logic [WIDTH-1:0]   mreg;
    logic               qm1;
    logic               neg_q;
    logic               div_zero;
    logic               div_ovf;

    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_sub;
    logic               add_carry;
    logic               add_ovf;

    logic               booth_do;
    logic [WIDTH-1:0]   booth_acc;
    logic               booth_sign;
    logic               start;

    assign start = ctrl_MULT | ctrl_DIV;

    always_comb begin
        add_a   = acc;
        add_b   = mreg;
        add_sub = 1'b0;
        case (state)
            MULT: add_sub = qreg[0] & ~qm1;
            DIV: begin
                add_sub = 1'b1;
                if (fin) begin
                    // Finishing cycle reuses the adder to negate the quotient.
                    add_a = '0;
                    add_b = qreg;
                end else begin
                    add_a = {acc[WIDTH-2:0], qreg[WIDTH-1]};
                end
            end
            default: ;
        endcase
    end

    addsub32 u_addsub (
        .a        (add_a),
        .b        (add_b),
        .sub      (add_sub),
        .sum      (add_sum),
        .carry    (add_carry),
        .overflow (add_ovf)
    );

    // The true sign of acc +/- M is sum[31]^overflow, so no 33rd accumulator bit is needed.
    assign booth_do   = qreg[0] ^ qm1;
    assign booth_acc  = booth_do ? add_sum : acc;
    assign booth_sign = booth_do ? (add_sum[WIDTH-1] ^ add_ovf) : acc[WIDTH-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            fin            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (start) begin
                state <= ctrl_MULT ? MULT : DIV;
                count <= '0;
                fin   <= 1'b0;
                busy  <= 1'b1;
                acc   <= '0;
                qm1   <= 1'b0;
                if (ctrl_MULT) begin
                    qreg <= data_operandA;
                    mreg <= data_operandB;
                end else begin
                    qreg     <= mag(data_operandA);
                    mreg     <= mag(data_operandB);
                    neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    div_zero <= (data_operandB == '0);
                    div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
                end
            end else begin
                case (state)
                    MULT, DIV: begin
                        if (fin) begin
                            state          <= DONE;
                            busy           <= 1'b0;
                            data_resultRDY <= 1'b1;
                            if (state == MULT) begin
                                data_result    <= qreg;
                                data_exception <= (acc != {WIDTH{qreg[WIDTH-1]}});
                            end else if (div_zero) begin
                                data_result    <= '0;
                                data_exception <= 1'b1;
                            end else if (div_ovf) begin
                                data_result    <= INT_MIN;
                                data_exception <= 1'b1;
                            end else begin
                                data_result    <= neg_q ? add_sum : qreg;
                                data_exception <= 1'b0;
                            end
                        end else begin
                            count <= count + 1'b1;
                            if (count == COUNT_W'(ITERS - 1)) fin <= 1'b1;
                            if (state == MULT) begin
                                acc  <= {booth_sign, booth_acc[WIDTH-1:1]};
                                qreg <= {booth_acc[0], qreg[WIDTH-1:1]};
                                qm1  <= qreg[0];
                            end else if (add_carry) begin
                                acc  <= add_sum;
                                qreg <= {qreg[WIDTH-2:0], 1'b1};
                            end else begin
                                acc  <= {acc[WIDTH-2:0], qreg[WIDTH-1]};
                                qreg <= {qreg[WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_seq.sv
// Randomized bench for multdiv_seq: a latency/arithmetic reference model checked every
// cycle, plus directed cases with hand-computed results.
module tb_multdiv_seq;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    multdiv_seq dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: {exception, result}
    function automatic logic [32:0] ref_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     q;
        if (is_mult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {(p[63:32] != {32{p[31]}}), p[31:0]};
        end
        if (b == 32'h0) return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    // Model: an accepted request produces its result 33 edges later unless superseded or reset.
    bit          pend;
    int          age;
    logic [32:0] p_val;
    bit          m_rdy, m_busy, m_exc;
    logic [31:0] m_res;

    always @(posedge clock) begin
        if (reset) begin
            pend = 0; m_rdy = 0; m_busy = 0; m_res = 0; m_exc = 0;
        end else begin
            m_rdy = 0;
            if (ctrl_MULT || ctrl_DIV) begin
                pend   = 1;
                age    = 0;
                p_val  = ref_op(ctrl_MULT, data_operandA, data_operandB);
                m_busy = 1;
            end else if (pend) begin
                age++;
                if (age == 33) begin
                    pend   = 0;
                    m_busy = 0;
                    m_rdy  = 1;
                    m_res  = p_val[31:0];
                    m_exc  = p_val[32];
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("rdy", data_resultRDY, m_rdy);
            check("busy", busy, m_busy);
            check("result", data_result, m_res);
            check("exception", data_exception, m_exc);
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT = m; ctrl_DIV = d; data_operandA = a; data_operandB = b;
        tick;
        ctrl_MULT = 0; ctrl_DIV = 0;
        data_operandA = $urandom; data_operandB = $urandom;
    endtask

    task automatic do_reset;
        reset = 1;
        tick;
        reset = 0;
    endtask

    task automatic wait_rdy(input string name, input logic [31:0] er, input logic ee);
        int lat, bcnt;
        bit seen;
        seen = 0; bcnt = 0; lat = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clock);
            if (busy) bcnt++;
            if (data_resultRDY) begin
                seen = 1;
                lat  = i - 1;
            end
        end
        check({name, "_seen"}, seen, 1);
        if (seen) begin
            check({name, "_latency"}, lat, 33);
            check({name, "_busycycles"}, bcnt, 33);
            check({name, "_result"}, data_result, er);
            check({name, "_exc"}, data_exception, ee);
        end
        tick;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($signed($urandom_range(0, 200)) - 100);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1; ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = 0; data_operandB = 0;
        tick;
        tick;
        chk_en = 1;
        reset  = 0;
        check("reset_result", data_result, 0);
        check("reset_exc", data_exception, 0);
        check("reset_rdy", data_resultRDY, 0);
        check("reset_busy", busy, 0);

        repeat (3) tick;
        check("idle_busy", busy, 0);

        pulse(1, 0, 32'd7, 32'hFFFF_FFFD);         wait_rdy("mul_7x-3", 32'hFFFF_FFEB, 0);
        pulse(1, 0, 32'h0001_0000, 32'h0001_0000); wait_rdy("mul_ovf", 32'h0, 1);
        pulse(1, 0, 32'h7FFF_FFFF, 32'hFFFF_FFFF); wait_rdy("mul_max_neg1", 32'h8000_0001, 0);
        pulse(1, 0, 32'h8000_0000, 32'h8000_0000); wait_rdy("mul_min_min", 32'h0, 1);
        pulse(0, 1, 32'hFFFF_FFEC, 32'd3);         wait_rdy("div_-20/3", 32'hFFFF_FFFA, 0);
        pulse(0, 1, 32'd20, 32'hFFFF_FFFD);        wait_rdy("div_20/-3", 32'hFFFF_FFFA, 0);
        pulse(0, 1, 32'hFFFF_FFEC, 32'hFFFF_FFFD); wait_rdy("div_-20/-3", 32'd6, 0);
        pulse(0, 1, 32'd5, 32'd0);                 wait_rdy("div_by_zero", 32'h0, 1);
        pulse(0, 1, 32'h8000_0000, 32'hFFFF_FFFF); wait_rdy("div_min_neg1", 32'h8000_0000, 1);
        pulse(0, 1, 32'h8000_0000, 32'd2);         wait_rdy("div_min_2", 32'hC000_0000, 0);

        // Restart mid-operation: only the second request completes.
        pulse(1, 0, 32'd3, 32'd4);
        for (int i = 0; i < 9; i++) begin
            check("restart_no_rdy", data_resultRDY, 0);
            tick;
        end
        pulse(0, 1, 32'd100, 32'd7);               wait_rdy("restart_div", 32'd14, 0);
        pulse(1, 1, 32'd6, 32'd2);                 wait_rdy("both_ctrl", 32'd12, 0);

        // Reset mid-divide abandons it.
        pulse(0, 1, 32'd9, 32'd3);
        repeat (14) tick;
        do_reset;
        for (int i = 0; i < 40; i++) begin
            check("abandon_rdy", data_resultRDY, 0);
            check("abandon_result", data_result, 0);
            tick;
        end
        pulse(1, 0, 32'd2, 32'd5);                 wait_rdy("after_reset_mul", 32'd10, 0);

        // Random traffic, including restarts, DONE-cycle restarts and rare resets.
        for (int n = 0; n < 250; n++) begin
            int kind, gap;
            kind = $urandom_range(0, 4);
            pulse(kind <= 1, kind >= 1, rnd_operand(), rnd_operand());
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 34) : 36;
            repeat (gap) tick;
            if ($urandom_range(0, 40) == 0) do_reset;
        end
        repeat (40) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
